// File: rtl/bounce_gen_pkg.sv
// Shared constants for the contact-bounce emulator: FSM encoding, LFSR shape,
// and the LFSR slice used for random pair counts.
package bounce_gen_pkg;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_BOUNCE = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;

  localparam int            LFSR_W    = 16;
  localparam logic [15:0]   LFSR_MASK = 16'hB400;

  localparam int RAND_PAIRS_MSB = 15;
  localparam int RAND_PAIRS_LSB = 13;
  localparam int RAND_PAIRS_MAX = 8;

  // Galois form, shifting right; feedback taken from bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ ({LFSR_W{s[0]}} & LFSR_MASK);
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR that supplies the bounce timing entropy.
module lfsr16
  import bounce_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] o_state
);

  logic [LFSR_W-1:0] state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= lfsr_next(state_q);
  end

  assign o_state = state_q;

endmodule

// File: rtl/bounce_gen.sv
// Contact-bounce emulator: each change of i_level becomes a burst of random-width
// toggles followed by a fixed settle dwell. BOUNCE_GEN_RAND_COUNT_EN randomises the pair count.
//
// state      | meaning
// IDLE       | output follows stored level, watching for i_level change
// BOUNCE     | toggling o_bounce each time the phase timer expires
// SETTLE     | output steady at stored level, counting down the dwell
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int          NUM_BOUNCES     = 4,
  parameter int          BOUNCE_MAX_LOG2 = 10,
  parameter int          SETTLE_CYCLES   = 1000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_bounce,
  output logic o_busy,
  output logic o_settled
);

`ifdef BOUNCE_GEN_RAND_COUNT_EN
  localparam int MAX_PAIRS = RAND_PAIRS_MAX;
`else
  localparam int MAX_PAIRS = NUM_BOUNCES;
`endif
  localparam int TOG_W = $clog2(2 * MAX_PAIRS + 1);
  localparam int TMR_W = BOUNCE_MAX_LOG2 + 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  logic [LFSR_W-1:0] lfsr_q;
  logic [TMR_W-1:0]  phase_len;
  logic [TOG_W-1:0]  tog_load;

  state_t            state_q, state_d;
  logic              level_q, level_d;
  logic              bounce_q, bounce_d;
  logic              settled_q, settled_d;
  logic [TOG_W-1:0]  tog_q, tog_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [SET_W-1:0]  set_q, set_d;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .o_state (lfsr_q)
  );

  generate
    if (BOUNCE_MAX_LOG2 == 0) begin : g_fixed_phase
      assign phase_len = TMR_W'(1);
    end else begin : g_rand_phase
      assign phase_len = {1'b0, lfsr_q[BOUNCE_MAX_LOG2-1:0]} + TMR_W'(1);
    end
  endgenerate

`ifdef BOUNCE_GEN_RAND_COUNT_EN
  assign tog_load = TOG_W'({1'b0, lfsr_q[RAND_PAIRS_MSB:RAND_PAIRS_LSB]} + 4'd1) << 1;
`else
  assign tog_load = TOG_W'(2 * NUM_BOUNCES);
`endif

  // Not every LFSR bit feeds the phase/pair slices in every configuration.
  logic unused_lfsr;
  assign unused_lfsr = ^lfsr_q;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    bounce_d  = bounce_q;
    tog_d     = tog_q;
    tmr_d     = tmr_q;
    set_d     = set_q;
    settled_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_level != level_q) begin
          level_d  = i_level;
          bounce_d = i_level;
          tog_d    = tog_load;
          tmr_d    = phase_len;
          state_d  = ST_BOUNCE;
        end
      end
      ST_BOUNCE: begin
        if (tmr_q == TMR_W'(1)) begin
          if (tog_q == TOG_W'(1)) begin
            // Even toggle count means this lands on the target level anyway.
            bounce_d = level_q;
            tog_d    = '0;
            tmr_d    = '0;
            set_d    = SET_W'(SETTLE_CYCLES);
            state_d  = ST_SETTLE;
          end else begin
            bounce_d = ~bounce_q;
            tog_d    = tog_q - TOG_W'(1);
            tmr_d    = phase_len;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SETTLE: begin
        set_d = set_q - SET_W'(1);
        if (set_q == SET_W'(1)) begin
          state_d   = ST_IDLE;
          settled_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      level_q   <= 1'b0;
      bounce_q  <= 1'b0;
      settled_q <= 1'b0;
      tog_q     <= '0;
      tmr_q     <= '0;
      set_q     <= '0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      bounce_q  <= bounce_d;
      settled_q <= settled_d;
      tog_q     <= tog_d;
      tmr_q     <= tmr_d;
      set_q     <= set_d;
    end
  end

  assign o_bounce  = bounce_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_settled = settled_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Directed-vector bench for bounce_gen: fixed-phase instance checked against a
// hand-computed table, random-phase instance checked against an LFSR model.
module tb_bounce_gen;

  localparam int NB_B = 2;

  logic clk;
  logic rst_a, rst_b;
  logic lvl_a, lvl_b;
  logic bnc_a, busy_a, stl_a;
  logic bnc_b, busy_b, stl_b;

  int checks   = 0;
  int failures = 0;

  bounce_gen #(
    .NUM_BOUNCES(2), .BOUNCE_MAX_LOG2(0), .SETTLE_CYCLES(4), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .clk(clk), .rst(rst_a), .i_level(lvl_a),
    .o_bounce(bnc_a), .o_busy(busy_a), .o_settled(stl_a)
  );

  bounce_gen #(
    .NUM_BOUNCES(NB_B), .BOUNCE_MAX_LOG2(4), .SETTLE_CYCLES(2), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .i_level(lvl_b),
    .o_bounce(bnc_b), .o_busy(busy_b), .o_settled(stl_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR for dut_b: right-shift Galois, mask B400.
  logic [15:0] mdl;
  always @(posedge clk or posedge rst_b) begin
    if (rst_b) mdl <= 16'hACE1;
    else       mdl <= {1'b0, mdl[15:1]} ^ (mdl[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct {
    logic       lvl;
    logic [2:0] exp;   // {o_bounce, o_busy, o_settled}
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic l, input logic [2:0] e, input int n);
    for (int k = 0; k < n; k++) vq.push_back('{l, e});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [15:0] pre;
  int          width, tog, exp_len, exp_tog;
  logic        prev;
  bit          done;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    lvl_a = 1'b0; lvl_b = 1'b0;
    tick(); tick();
    chk("reset_a", {29'd0, bnc_a, busy_a, stl_a}, 32'd0);
    chk("reset_b", {29'd0, bnc_b, busy_b, stl_b}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;

    for (int c = 0; c < 100; c++) begin
      tick();
      chk("idle_a", {29'd0, bnc_a, busy_a, stl_a}, 32'd0);
      chk("idle_b", {29'd0, bnc_b, busy_b, stl_b}, 32'd0);
    end

    // Rising edge, edges 0..9
    add(1, 3'b110, 1); add(1, 3'b010, 1); add(1, 3'b110, 1); add(1, 3'b010, 1);
    add(1, 3'b110, 4); add(1, 3'b101, 1); add(1, 3'b100, 1);
    // Falling edge, edges 0..10
    add(0, 3'b010, 1); add(0, 3'b110, 1); add(0, 3'b010, 1); add(0, 3'b110, 1);
    add(0, 3'b010, 4); add(0, 3'b001, 1); add(0, 3'b000, 2);
    // Input falls back at edge 2 during a rising burst
    add(1, 3'b110, 1); add(1, 3'b010, 1); add(0, 3'b110, 1); add(0, 3'b010, 1);
    add(0, 3'b110, 4); add(0, 3'b101, 1);
    add(0, 3'b010, 1); add(0, 3'b110, 1); add(0, 3'b010, 1); add(0, 3'b110, 1);
    add(0, 3'b010, 4); add(0, 3'b001, 1); add(0, 3'b000, 1);

    for (int i = 0; i < vq.size(); i++) begin
      lvl_a = vq[i].lvl;
      tick();
      chk($sformatf("vec[%0d]", i), {29'd0, bnc_a, busy_a, stl_a}, {29'd0, vq[i].exp});
    end

    // Reset in the middle of a burst, i_level held high through release
    lvl_a = 1'b1;
    tick();
    chk("mid_e0", {29'd0, bnc_a, busy_a, stl_a}, 32'b110);
    tick();
    chk("mid_e1", {29'd0, bnc_a, busy_a, stl_a}, 32'b010);
    #3 rst_a = 1'b1;
    #1;
    chk("mid_async_rst", {29'd0, bnc_a, busy_a, stl_a}, 32'd0);
    tick();
    chk("mid_held_rst", {29'd0, bnc_a, busy_a, stl_a}, 32'd0);
    rst_a = 1'b0;
    tick();
    chk("mid_restart", {29'd0, bnc_a, busy_a, stl_a}, 32'b110);
    for (int c = 1; c < 8; c++) tick();
    tick();
    chk("mid_settled", {29'd0, bnc_a, busy_a, stl_a}, 32'b101);

    // Random phase widths on dut_b, checked against the reference LFSR
    for (int t = 0; t < 1000; t++) begin
      lvl_b = ~lvl_b;
      pre = mdl;
      tick();
      exp_len = int'(pre[3:0]) + 1;
`ifdef BOUNCE_GEN_RAND_COUNT_EN
      exp_tog = 2 * (int'(pre[15:13]) + 1);
`else
      exp_tog = 2 * NB_B;
`endif
      chk("rnd_first_contact", {31'd0, bnc_b}, {31'd0, lvl_b});
      chk("rnd_busy_start", {31'd0, busy_b}, 32'd1);
      prev = bnc_b; width = 1; tog = 0; done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
        pre = mdl;
        tick();
        if (bnc_b !== prev) begin
          chk("rnd_phase_width", width, exp_len);
          tog++;
          width = 1;
          prev = bnc_b;
          exp_len = int'(pre[3:0]) + 1;
        end else begin
          width++;
        end
        if (stl_b) done = 1'b1;
      end
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL rnd_timeout transition=%0d settled=0 required=1", t);
      end
      chk("rnd_toggles", tog, exp_tog);
      chk("rnd_final_level", {31'd0, bnc_b}, {31'd0, lvl_b});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
